instr_fetch_sequencer: RTL and testbench
========================================

# instr_fetch_sequencer

Instruction fetch sequencer for the simple CPU: holds the program counter, reads one 16-bit instruction per step from instruction memory over a request/acknowledge handshake, latches it into the instruction register, then starts `fsm_controller` via `s` and waits for it to return to its wait state (`w`). It sits between instruction memory and the datapath controller and is the only driver of `s`.

## Interface
- `ADDR_W`, 8: PC / memory address width.
- `RESET_PC`, 0: PC value after reset.
- `clk`  input  1  clock; all state changes on rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `run`  input  1  enable fetching; sampled in IDLE and at end of each instruction.
- `mem_addr`  output  ADDR_W  instruction address; equals `pc`.
- `mem_rd`  output  1  read request; high throughout FETCH.
- `mem_ack`  input  1  read complete; `mem_rdata` valid in the same cycle.
- `mem_rdata`  input  16  instruction word.
- `ir`  output  16  instruction register; drives `opcode = ir[15:13]`, `op = ir[12:11]` into `fsm_controller`.
- `s`  output  1  start request to `fsm_controller`.
- `w`  input  1  `fsm_controller` in wait state.
- `pc`  output  ADDR_W  program counter.
- `busy`  output  1  high in any state except IDLE and HALT.
- `halted`  output  1  HALT state indicator.

## Operation
- States: IDLE, FETCH, ISSUE, EXEC, HALT. All outputs registered or pure state decodes.
- Reset (async): state IDLE, `pc=RESET_PC`, `ir=0`, `s=0`, `mem_rd=0`, `busy=0`, `halted=0`.
- IDLE: `run=1` -> FETCH; else stay.
- FETCH: `mem_rd=1`, `mem_addr=pc`. On edge with `mem_ack=1`: `ir<=mem_rdata`, -> ISSUE (or HALT, see Configuration). `mem_ack` while not in FETCH ignored.
- ISSUE: `s=1`. Hold until edge where `w=0` (controller left wait) -> EXEC. `s` stays high until that edge.
- EXEC: `s=0`. On edge where `w=1`: `pc<=pc+1` (mod 2^ADDR_W; max value wraps to 0); -> FETCH if `run=1`, else IDLE.
- `run` falling mid-instruction does not abort; current instruction completes, PC increments, then IDLE.
- `ir` holds its value from capture until the next `mem_ack` in FETCH.

## Timing
- Zero-wait memory (`mem_ack` high in the first FETCH cycle): FETCH 1 cycle, ISSUE >=1 cycle, EXEC until `w` returns; minimum 3 cycles per instruction plus controller execution.
- `ir` visible at `fsm_controller` the cycle `s` first rises (ISSUE entered after capture edge).
- `pc` update and new `mem_addr` visible the cycle after leaving EXEC, same cycle `mem_rd` rises.
- Reset asserted mid-operation: `s` and `mem_rd` drop immediately (combinationally via async reset), no PC increment; outstanding memory request abandoned.
- Reset released: first FETCH no earlier than the second rising edge after release with `run=1`.

## Configuration
- `FETCH_HALT_EN` defined: in FETCH, if `mem_rdata[15:13]==3'b111` on the `mem_ack` edge, `ir` is loaded and the state goes to HALT instead of ISSUE; `s` never asserted, `pc` not incremented, `halted=1`, `busy=0`; only `reset` exits HALT.
- Not defined: opcode 111 treated like any other instruction (ISSUE/EXEC); HALT state absent; `halted` tied 0.

## Test plan
- Reset with `RESET_PC=0`, `run=0` for 5 cycles -> `pc=0`, `s=0`, `mem_rd=0`, `busy=0`, state IDLE throughout.
- `run=1`, memory acks in 1 cycle with `16'hA000`, controller drops `w` 1 cycle after `s`, raises it 4 cycles later -> `ir=16'hA000`, `s` high exactly 1 cycle, `pc` 0->1, next `mem_rd` with `mem_addr=1`.
- Memory ack delayed 3 cycles -> `mem_rd` high 3 cycles, `mem_addr` stable, `ir` unchanged until ack edge, `s` low throughout FETCH.
- `ADDR_W=8`, `RESET_PC=8'hFF`, one instruction completes -> `pc=8'h00`, `mem_addr=8'h00`.
- `run` dropped during EXEC -> instruction completes, `pc` increments once, state IDLE, no further `mem_rd`; reset asserted during ISSUE -> `s=0` same cycle, `pc=RESET_PC`.
- With `FETCH_HALT_EN`, fetch `16'hE000` at `pc=2` -> `halted=1`, `pc=2`, `s` never asserted, `run` toggling has no effect until reset; without macro, same word issues `s` normally.

Source files
------------

// File: rtl/instr_fetch_sequencer.sv
// Instruction fetch sequencer: PC, memory read handshake, IR, start of fsm_controller.
// Optional halt-on-fetch of opcode 3'b111 is enabled by defining FETCH_HALT_EN.
module instr_fetch_sequencer #(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic              mem_ack,
    input  logic [15:0]       mem_rdata,
    output logic [15:0]       ir,
    output logic              s,
    input  logic              w,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              halted
);

`ifdef FETCH_HALT_EN
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_ISSUE,
        ST_EXEC,
        ST_HALT
    } state_e;
`else
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_ISSUE,
        ST_EXEC
    } state_e;
`endif

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [15:0]       ir_q, ir_d;
    logic              s_q, s_d;
    logic              mem_rd_q, mem_rd_d;
    logic              busy_q, busy_d;
    logic              halted_q, halted_d;

    // Next state, PC/IR updates, and outputs decoded from the next state so they register cleanly
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        case (state_q)
            ST_IDLE: begin
                if (run) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (mem_ack) begin
                    ir_d    = mem_rdata;
                    state_d = ST_ISSUE;
`ifdef FETCH_HALT_EN
                    if (mem_rdata[15:13] == 3'b111) state_d = ST_HALT;
`endif
                end
            end
            ST_ISSUE: begin
                if (!w) state_d = ST_EXEC;
            end
            ST_EXEC: begin
                if (w) begin
                    pc_d    = pc_q + ADDR_W'(1);
                    state_d = run ? ST_FETCH : ST_IDLE;
                end
            end
            default: state_d = state_q;
        endcase

        s_d      = (state_d == ST_ISSUE);
        mem_rd_d = (state_d == ST_FETCH);
        busy_d   = (state_d == ST_FETCH) || (state_d == ST_ISSUE) || (state_d == ST_EXEC);
`ifdef FETCH_HALT_EN
        halted_d = (state_d == ST_HALT);
`else
        halted_d = 1'b0;
`endif
    end

    // State and registered outputs; async reset drops s and mem_rd immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            pc_q     <= RESET_PC;
            ir_q     <= '0;
            s_q      <= 1'b0;
            mem_rd_q <= 1'b0;
            busy_q   <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            s_q      <= s_d;
            mem_rd_q <= mem_rd_d;
            busy_q   <= busy_d;
            halted_q <= halted_d;
        end
    end

    assign pc       = pc_q;
    assign mem_addr = pc_q;
    assign ir       = ir_q;
    assign s        = s_q;
    assign mem_rd   = mem_rd_q;
    assign busy     = busy_q;
`ifdef FETCH_HALT_EN
    assign halted   = halted_q;
`else
    assign halted   = 1'b0;
    logic unused_halted;
    assign unused_halted = halted_q;
`endif

endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// Bench for instr_fetch_sequencer: vector table, directed reset case, random vs. model.
// Two instances share inputs; the second starts at PC 8'hFF to exercise wrap.
module tb_instr_fetch_sequencer;

    logic        clk;
    logic        reset;
    logic        run;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic        w;

    logic [7:0]  mem_addr, pc, addr_ff, pc_ff;
    logic        mem_rd, s, busy, halted;
    logic        mem_rd_ff, s_ff, busy_ff, halted_ff;
    logic [15:0] ir, ir_ff;

    int n_checks = 0;
    int n_err    = 0;

    instr_fetch_sequencer #(.ADDR_W(8), .RESET_PC(8'h00)) u_dut (
        .clk(clk), .reset(reset), .run(run),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .ir(ir), .s(s), .w(w),
        .pc(pc), .busy(busy), .halted(halted)
    );

    instr_fetch_sequencer #(.ADDR_W(8), .RESET_PC(8'hFF)) u_ff (
        .clk(clk), .reset(reset), .run(run),
        .mem_addr(addr_ff), .mem_rd(mem_rd_ff), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .ir(ir_ff), .s(s_ff), .w(w),
        .pc(pc_ff), .busy(busy_ff), .halted(halted_ff)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef FETCH_HALT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    typedef struct {
        logic        run;
        logic        ack;
        logic [15:0] rdata;
        logic        w;
        logic        s;
        logic        rd;
        logic        busy;
        logic        halt;
        logic [7:0]  pc;
        logic [15:0] ir;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic r, logic a, logic [15:0] d, logic ww,
                                logic es, logic erd, logic eb, logic eh,
                                logic [7:0] epc, logic [15:0] eir);
        vec_t v;
        v.run = r; v.ack = a; v.rdata = d; v.w = ww;
        v.s = es; v.rd = erd; v.busy = eb; v.halt = eh;
        v.pc = epc; v.ir = eir;
        return v;
    endfunction

    function automatic logic [63:0] pack(logic es, logic erd, logic eb, logic eh,
                                         logic [7:0] epc, logic [15:0] eir,
                                         logic [7:0] epcff);
        return {12'b0, es, erd, eb, eh, epc, epc, eir, epcff, epcff};
    endfunction

    function automatic logic [63:0] actual();
        return {12'b0, s, mem_rd, busy, halted, pc, mem_addr, ir, pc_ff, addr_ff};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic a, input logic [15:0] d, input logic ww);
        run = r; mem_ack = a; mem_rdata = d; w = ww;
        @(negedge clk);
    endtask

    localparam int M_IDLE  = 0;
    localparam int M_FETCH = 1;
    localparam int M_ISSUE = 2;
    localparam int M_EXEC  = 3;
    localparam int M_HALT  = 4;

    initial begin
        int          ph;
        int          cnt;
        int          hcyc;
        logic [15:0] m_ir;
        logic        r_rst;
        logic [7:0]  p0, pf;

        reset = 1'b1; run = 1'b0; mem_ack = 1'b0; mem_rdata = '0; w = 1'b1;
        @(negedge clk);
        chk("reset_async", actual(), pack(0, 0, 0, 0, 8'h00, 16'h0000, 8'hFF));
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("reset_idle", actual(), pack(0, 0, 0, 0, 8'h00, 16'h0000, 8'hFF));
        end

        tbl.push_back(mk(0, 0, 16'h0000, 1, 0, 0, 0, 0, 8'd0, 16'h0000));
        tbl.push_back(mk(1, 0, 16'h0000, 1, 0, 1, 1, 0, 8'd0, 16'h0000));
        tbl.push_back(mk(1, 1, 16'hA000, 1, 1, 0, 1, 0, 8'd0, 16'hA000));
        tbl.push_back(mk(1, 0, 16'h0000, 0, 0, 0, 1, 0, 8'd0, 16'hA000));
        tbl.push_back(mk(1, 1, 16'hBEEF, 0, 0, 0, 1, 0, 8'd0, 16'hA000));
        tbl.push_back(mk(1, 0, 16'h0000, 0, 0, 0, 1, 0, 8'd0, 16'hA000));
        tbl.push_back(mk(1, 0, 16'h0000, 1, 0, 1, 1, 0, 8'd1, 16'hA000));
        tbl.push_back(mk(1, 0, 16'h0000, 1, 0, 1, 1, 0, 8'd1, 16'hA000));
        tbl.push_back(mk(1, 0, 16'h0000, 1, 0, 1, 1, 0, 8'd1, 16'hA000));
        tbl.push_back(mk(1, 1, 16'h1234, 1, 1, 0, 1, 0, 8'd1, 16'h1234));
        tbl.push_back(mk(1, 0, 16'h0000, 1, 1, 0, 1, 0, 8'd1, 16'h1234));
        tbl.push_back(mk(0, 0, 16'h0000, 0, 0, 0, 1, 0, 8'd1, 16'h1234));
        tbl.push_back(mk(0, 0, 16'h0000, 1, 0, 0, 0, 0, 8'd2, 16'h1234));
        tbl.push_back(mk(0, 1, 16'hFFFF, 1, 0, 0, 0, 0, 8'd2, 16'h1234));
        tbl.push_back(mk(1, 0, 16'h0000, 1, 0, 1, 1, 0, 8'd2, 16'h1234));
        if (HALT_EN) begin
            tbl.push_back(mk(1, 1, 16'hE000, 1, 0, 0, 0, 1, 8'd2, 16'hE000));
            tbl.push_back(mk(0, 0, 16'h0000, 0, 0, 0, 0, 1, 8'd2, 16'hE000));
            tbl.push_back(mk(1, 1, 16'h0001, 1, 0, 0, 0, 1, 8'd2, 16'hE000));
        end else begin
            tbl.push_back(mk(1, 1, 16'hE000, 1, 1, 0, 1, 0, 8'd2, 16'hE000));
            tbl.push_back(mk(0, 0, 16'h0000, 0, 0, 0, 1, 0, 8'd2, 16'hE000));
            tbl.push_back(mk(1, 1, 16'h0001, 1, 0, 1, 1, 0, 8'd3, 16'hE000));
        end

        foreach (tbl[i]) begin
            drive(tbl[i].run, tbl[i].ack, tbl[i].rdata, tbl[i].w);
            chk($sformatf("vec%0d", i), actual(),
                pack(tbl[i].s, tbl[i].rd, tbl[i].busy, tbl[i].halt,
                     tbl[i].pc, tbl[i].ir, tbl[i].pc + 8'hFF));
        end

        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        drive(1, 0, 16'h0000, 1);
        drive(1, 1, 16'h0001, 1);
        drive(1, 0, 16'h0000, 0);
        drive(1, 0, 16'h0000, 1);
        drive(1, 1, 16'h0002, 1);
        chk("issue_before_reset", actual(), pack(1, 0, 1, 0, 8'd1, 16'h0002, 8'd0));
        #2 reset = 1'b1;
        #1 chk("reset_in_issue", actual(), pack(0, 0, 0, 0, 8'd0, 16'h0000, 8'hFF));
        @(negedge clk);

        ph = M_IDLE; cnt = 0; hcyc = 0; m_ir = '0;
        for (int i = 0; i < 3000; i++) begin
            if (i > 0) begin
                p0 = 8'(cnt);
                pf = 8'(cnt + 255);
                chk("random", actual(),
                    pack(ph == M_ISSUE, ph == M_FETCH,
                         ph == M_FETCH || ph == M_ISSUE || ph == M_EXEC,
                         ph == M_HALT, p0, m_ir, pf));
            end
            r_rst     = (i == 0) || ($urandom_range(0, 99) == 0) || (hcyc > 8);
            reset     = r_rst;
            run       = ($urandom_range(0, 3) != 0);
            mem_ack   = $urandom_range(0, 1) == 1;
            mem_rdata = 16'($urandom);
            w         = $urandom_range(0, 1) == 1;
            if (r_rst) begin
                ph = M_IDLE; cnt = 0; m_ir = '0; hcyc = 0;
            end else begin
                case (ph)
                    M_IDLE:  if (run) ph = M_FETCH;
                    M_FETCH: if (mem_ack) begin
                        m_ir = mem_rdata;
                        ph = (HALT_EN && mem_rdata[15:13] == 3'b111) ? M_HALT : M_ISSUE;
                    end
                    M_ISSUE: if (!w) ph = M_EXEC;
                    M_EXEC:  if (w) begin
                        cnt++;
                        ph = run ? M_FETCH : M_IDLE;
                    end
                    default: hcyc++;
                endcase
            end
            @(negedge clk);
        end
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
